palindrome_stats: RTL
=====================

# palindrome_stats

Downstream consumer of the 3-bit palindrome detector output. Samples the detector's per-cycle palindrome flag and accumulates statistics over fixed frames of WINDOW armed cycles. At the end of each frame it emits a report (hit count, longest run of consecutive hits, overrun flag) over a valid/ready interface to the status/CSR logic. Holds one report; frames that complete while the report register is blocked are dropped and flagged.

## Interface
- WINDOW, default 16: armed samples per report frame; legal range 2..2^CNT_W-1.
- CNT_W, default 5: width of count fields; must satisfy 2^CNT_W > WINDOW.
- clk  in  1  clock; all flops positive-edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- palindrome_i  in  1  detector output for the current cycle.
- armed_i  in  1  high when palindrome_i is meaningful (detector pipe primed); low cycles are ignored.
- rpt_valid_o  out  1  report register holds an unaccepted report.
- rpt_ready_i  in  1  consumer accepts report when high with rpt_valid_o.
- rpt_hits_o  out  CNT_W  number of palindrome_i=1 samples in the frame.
- rpt_max_run_o  out  CNT_W  longest run of consecutive armed hits in the frame.
- rpt_overrun_o  out  1  at least one frame was dropped since the previous delivered report.

## Operation
- Accumulator: frame position counter pos (0..WINDOW-1), hit counter, current run cur_run, max run max_run; all advance only on cycles with armed_i=1.
- Armed sample: hits += palindrome_i; if palindrome_i=1, cur_run += 1 and max_run = max(max_run, cur_run+1); else cur_run = 0.
- Unarmed cycle (armed_i=0): pos, hits, max_run held; cur_run cleared (a gap breaks a run).
- Frame end: an armed sample with pos=WINDOW-1. Final values include that sample. pos, hits, cur_run, max_run all return to 0 for the next frame. Runs never span frames.
- Report register, two states: EMPTY (rpt_valid_o=0) and FULL (rpt_valid_o=1).
  - EMPTY + frame end: load report, go FULL.
  - FULL + rpt_ready_i=1: report consumed; if frame end happens in the same cycle, load the new report and stay FULL; otherwise go EMPTY.
  - FULL + rpt_ready_i=0 + frame end: the new frame is discarded and the sticky lost flag is set.
- Overrun: the sticky lost flag is copied into rpt_overrun_o on the next report load and is then cleared. A load and a loss never occur in the same cycle.
- Field widths: no counter can exceed WINDOW, so no saturation logic is needed. The parameter constraint guarantees this.

## Timing
- Reset (synchronous): rpt_valid_o=0, rpt_hits_o=0, rpt_max_run_o=0, rpt_overrun_o=0. pos, hits, cur_run, max_run and the lost flag are all 0.
- Reset mid-frame discards the partial frame and any pending report without reporting them. Counting restarts at the first armed sample after reset deasserts.
- Latency: rpt_valid_o rises in the cycle after the clock edge that samples the frame's last armed input.
- Handshake:
  - Report fields are stable while rpt_valid_o=1 and rpt_ready_i=0.
  - Transfer occurs on the edge where both are high.
  - rpt_valid_o does not depend combinationally on rpt_ready_i.
- Throughput: one report per WINDOW armed cycles when rpt_ready_i is held high. There are no bubbles between back-to-back frames.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- WINDOW=4, CNT_W=3, armed=1, ready=1, palindrome 1,1,0,1 -> one cycle after 4th sample: valid=1, hits=3, max_run=2, overrun=0. Valid drops the following cycle.
- palindrome=1 constant, armed 1,0,1,1,1 -> report after 5th cycle: hits=4, max_run=3 (the gap breaks the run).
- All-ones for 4 armed cycles, then all-zeros for 4 -> reports {hits=4, max_run=4} then {hits=0, max_run=0}, back-to-back with no idle cycle.
- ready=0, palindrome=0 for 12 armed cycles -> first report {hits=0, overrun=0} held stable, frames 2-3 dropped.
  - Then ready=1 and 4 more armed samples of 1 -> first report delivered, then {hits=4, max_run=4, overrun=1}, then next report overrun=0.
- Report pending, ready=1 in the same cycle as the next frame end -> old report accepted, new report valid next cycle, overrun=0.
- 2 armed samples of 1, then reset for 1 cycle, then 4 samples 0,1,1,0 -> single report hits=2, max_run=2; no report from the pre-reset partial frame.

Source files
------------

// File: rtl/palindrome_stats_if.sv
// Report channel from palindrome_stats to the status/CSR logic.
interface palindrome_stats_if #(
    parameter int unsigned CNT_W = 5
);
    logic             rpt_valid_o;
    logic             rpt_ready_i;
    logic [CNT_W-1:0] rpt_hits_o;
    logic [CNT_W-1:0] rpt_max_run_o;
    logic             rpt_overrun_o;

    // Producer side (the statistics block)
    modport master (
        output rpt_valid_o,
        output rpt_hits_o,
        output rpt_max_run_o,
        output rpt_overrun_o,
        input  rpt_ready_i
    );

    // Consumer side (status/CSR logic)
    modport slave (
        input  rpt_valid_o,
        input  rpt_hits_o,
        input  rpt_max_run_o,
        input  rpt_overrun_o,
        output rpt_ready_i
    );
endinterface

// File: rtl/palindrome_stats.sv
// Frame statistics for the palindrome detector: hit count and longest hit run
// per WINDOW armed samples, delivered through a one-entry report register.
module palindrome_stats #(
    parameter int unsigned WINDOW = 16,
    parameter int unsigned CNT_W  = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               palindrome_i,
    input  logic               armed_i,
    palindrome_stats_if.master rpt
);
    typedef enum logic {EMPTY, FULL} state_t;

    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WINDOW - 1);

    state_t           state;
    logic [CNT_W-1:0] pos;
    logic [CNT_W-1:0] hits;
    logic [CNT_W-1:0] cur_run;
    logic [CNT_W-1:0] max_run;
    logic             lost;

    logic [CNT_W-1:0] rpt_hits_q;
    logic [CNT_W-1:0] rpt_max_run_q;
    logic             rpt_overrun_q;

    logic             frame_end_c;
    logic [CNT_W-1:0] hits_next_c;
    logic [CNT_W-1:0] run_next_c;
    logic [CNT_W-1:0] max_next_c;

    // Values the accumulator would hold after absorbing the current sample
    always_comb begin
        frame_end_c = armed_i && (pos == LAST_POS);
        hits_next_c = hits + CNT_W'(palindrome_i);
        run_next_c  = cur_run + CNT_W'(1);
        max_next_c  = (palindrome_i && (run_next_c > max_run)) ? run_next_c : max_run;
    end

    // Accumulator plus report register; a report load captures the final frame values
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= EMPTY;
            pos           <= '0;
            hits          <= '0;
            cur_run       <= '0;
            max_run       <= '0;
            lost          <= 1'b0;
            rpt_hits_q    <= '0;
            rpt_max_run_q <= '0;
            rpt_overrun_q <= 1'b0;
        end else begin
            if (armed_i) begin
                if (frame_end_c) begin
                    pos     <= '0;
                    hits    <= '0;
                    cur_run <= '0;
                    max_run <= '0;
                end else begin
                    pos     <= pos + CNT_W'(1);
                    hits    <= hits_next_c;
                    cur_run <= palindrome_i ? run_next_c : '0;
                    max_run <= max_next_c;
                end
            end else begin
                cur_run <= '0;
            end

            case (state)
                EMPTY: begin
                    if (frame_end_c) begin
                        state         <= FULL;
                        rpt_hits_q    <= hits_next_c;
                        rpt_max_run_q <= max_next_c;
                        rpt_overrun_q <= lost;
                        lost          <= 1'b0;
                    end
                end
                FULL: begin
                    if (rpt.rpt_ready_i) begin
                        if (frame_end_c) begin
                            rpt_hits_q    <= hits_next_c;
                            rpt_max_run_q <= max_next_c;
                            rpt_overrun_q <= lost;
                            lost          <= 1'b0;
                        end else begin
                            state <= EMPTY;
                        end
                    end else if (frame_end_c) begin
                        lost <= 1'b1;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    // Report channel driven straight from registers
    assign rpt.rpt_valid_o   = (state == FULL);
    assign rpt.rpt_hits_o    = rpt_hits_q;
    assign rpt.rpt_max_run_o = rpt_max_run_q;
    assign rpt.rpt_overrun_o = rpt_overrun_q;
endmodule
